// File: rtl/accept_decide.sv
// ============================================================================
// accept_decide: annealing accept/reject decision (prob vs. LFSR uniform draw)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module accept_decide #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      prob,
  input  logic             prob_valid,
  input  logic             force_accept,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             clear_stats,
  output logic             accept,
  output logic             accept_valid,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] reject_count
);

  localparam logic [31:0]      LFSR_TAPS  = 32'h80200003;
  localparam logic [31:0]      LFSR_INIT  = 32'hACE12468;
  localparam logic [24:0]      P_ONE      = 25'h1000000;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [31:0]      lfsr_q, lfsr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_prob_q, s1_prob_d;
  logic             s1_force_q, s1_force_d;
  logic [23:0]      s1_r_q, s1_r_d;
  logic             accept_q, accept_d;
  logic             accept_valid_q, accept_valid_d;
  logic [CNT_W-1:0] accept_count_q, accept_count_d;
  logic [CNT_W-1:0] reject_count_q, reject_count_d;

  logic [7:0]       exp_f;
  logic [22:0]      mant_f;
  logic [7:0]       shamt;
  logic [24:0]      p;

  // Float to Q0.24 probability; anything non-positive or NaN never accepts.
  always_comb begin
    exp_f  = s1_prob_q[30:23];
    mant_f = s1_prob_q[22:0];
    shamt  = 8'd126 - exp_f;
    p      = 25'd0;
    if (s1_prob_q[31] || (exp_f == 8'd0)) begin
      p = 25'd0;
    end else if ((exp_f == 8'hFF) && (mant_f != 23'd0)) begin
      p = 25'd0;
    end else if (exp_f >= 8'd127) begin
      p = P_ONE;
    end else if (shamt >= 8'd24) begin
      p = 25'd0;
    end else begin
      p = {2'b01, mant_f} >> shamt[4:0];
    end
  end

  always_comb begin
    // Stage 1 samples the current LFSR state, so a coincident seed_load
    // still uses the pre-load value.
    if (seed_load) begin
      lfsr_d = (seed == 32'd0) ? 32'h00000001 : seed;
    end else begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end

    s1_valid_d = prob_valid;
    s1_prob_d  = prob_valid ? prob         : s1_prob_q;
    s1_force_d = prob_valid ? force_accept : s1_force_q;
    s1_r_d     = prob_valid ? lfsr_q[23:0] : s1_r_q;

    accept_valid_d = s1_valid_q;
    accept_d       = s1_valid_q ? (s1_force_q | ({1'b0, s1_r_q} < p)) : accept_q;

    accept_count_d = accept_count_q;
    reject_count_d = reject_count_q;
    if (clear_stats) begin
      accept_count_d = '0;
      reject_count_d = '0;
    end else if (accept_valid_q) begin
      if (accept_q && (accept_count_q != CNT_MAX)) begin
        accept_count_d = accept_count_q + CNT_ONE;
      end
      if (!accept_q && (reject_count_q != CNT_MAX)) begin
        reject_count_d = reject_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q         <= LFSR_INIT;
      s1_valid_q     <= 1'b0;
      s1_prob_q      <= 32'd0;
      s1_force_q     <= 1'b0;
      s1_r_q         <= 24'd0;
      accept_q       <= 1'b0;
      accept_valid_q <= 1'b0;
      accept_count_q <= '0;
      reject_count_q <= '0;
    end else begin
      lfsr_q         <= lfsr_d;
      s1_valid_q     <= s1_valid_d;
      s1_prob_q      <= s1_prob_d;
      s1_force_q     <= s1_force_d;
      s1_r_q         <= s1_r_d;
      accept_q       <= accept_d;
      accept_valid_q <= accept_valid_d;
      accept_count_q <= accept_count_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign accept       = accept_q;
  assign accept_valid = accept_valid_q;
  assign accept_count = accept_count_q;
  assign reject_count = reject_count_q;

endmodule

`default_nettype wire
